// File: rtl/aes256_key_expansion.sv
// AES-256 key schedule: accepts a 256-bit key and expands one 32-bit word per clock
// into 60 word registers, which are presented directly as the 15 round keys.
module aes256_key_expansion #(
  parameter int ROUND_NUMBER = 14,
  parameter int KEY_WIDTH    = 256
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [KEY_WIDTH-1:0]          key_in_tdata,
  input  logic                          key_in_tvalid,
  output logic                          key_in_tready,
  output logic [ROUND_NUMBER:0][127:0]  round_keys,
  output logic                          round_keys_valid
);

  localparam int        NUM_WORDS = 4 * (ROUND_NUMBER + 1);
  localparam int        KEY_WORDS = KEY_WIDTH / 32;
  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  // Forward S-box, first entry (input 0x00) in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] w_q [NUM_WORDS];
  logic [5:0]  idx_q;
  logic [7:0]  rcon_q;
  logic        load, step;
  logic [31:0] prev_word, back_word, sub_in, sub_out, temp_word, new_word;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    state_d          = state_q;
    load             = 1'b0;
    step             = 1'b0;
    key_in_tready    = 1'b0;
    round_keys_valid = 1'b0;
    case (state_q)
      IDLE: begin
        key_in_tready = 1'b1;
        if (key_in_tvalid) begin
          load    = 1'b1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        step = 1'b1;
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        key_in_tready    = 1'b1;
        round_keys_valid = 1'b1;
        if (key_in_tvalid) begin
          load    = 1'b1;
          state_d = EXPAND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single SubWord instance shared by the RotWord (idx%8==0) and plain (idx%8==4) steps.
  always_comb begin
    prev_word = w_q[idx_q - 6'd1];
    back_word = w_q[idx_q - 6'd8];
    sub_in    = (idx_q[2:0] == 3'd0) ? rot_word(prev_word) : prev_word;
    sub_out   = sub_word(sub_in);
    case (idx_q[2:0])
      3'd0:    temp_word = sub_out ^ {rcon_q, 24'h000000};
      3'd4:    temp_word = sub_out;
      default: temp_word = prev_word;
    endcase
    new_word = back_word ^ temp_word;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      rcon_q  <= 8'h01;
      for (int i = 0; i < NUM_WORDS; i++) w_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      if (load) begin
        for (int i = 0; i < KEY_WORDS; i++) w_q[i] <= key_in_tdata[KEY_WIDTH-1-32*i -: 32];
        idx_q  <= 6'(KEY_WORDS);
        rcon_q <= 8'h01;
      end else if (step) begin
        w_q[idx_q] <= new_word;
        if (idx_q[2:0] == 3'd0) rcon_q <= xtime(rcon_q);
        if (idx_q != LAST_IDX) idx_q <= idx_q + 6'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k <= ROUND_NUMBER; k++)
      round_keys[k] = {w_q[4*k], w_q[4*k+1], w_q[4*k+2], w_q[4*k+3]};
  end

endmodule
